// File: rtl/keypad_matrix_scanner.sv
// -----------------------------------------------------------------------------
// keypad_matrix_scanner
//
// Scans a 4x4 key matrix one column at a time. Each key press is debounced over
// whole scans. An accepted single press is turned into one write on the LED
// display's data/load/char_position interface.
//
// Ports
//   clk            in   1  system clock
//   reset          in   1  synchronous, active-high reset
//   ena            in   1  1 = run, 0 = freeze divider/scan/FSM (load forced 0)
//   row_in         in   4  matrix rows, active-high, asynchronous to clk
//   col_out        out  4  one-hot active-high column drive
//   data_out       out  4  last accepted key code (row*4 + col)
//   char_position  out  2  display slot of the current/next write
//   load           out  1  one-cycle write strobe to the display
//   key_held       out  1  high while an accepted key is still held down
//   multi_key      out  1  last completed scan saw two or more keys
// -----------------------------------------------------------------------------
module keypad_matrix_scanner #(
  parameter logic [15:0] SCAN_DIV       = 16'd1000,
  parameter logic [7:0]  DEBOUNCE_SCANS = 8'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] data_out,
  output logic [1:0] char_position,
  output logic       load,
  output logic       key_held,
  output logic       multi_key
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;

  // Row synchronizer
  logic [3:0]  sync1_q, sync1_d;
  logic [3:0]  sync2_q, sync2_d;

  // Column scan
  logic [15:0] div_cnt_q, div_cnt_d;
  logic [3:0]  col_q, col_d;
  logic [15:0] scan_buf_q, scan_buf_d;   // bit row*4+col = key seen pressed
  logic        scan_cmp_q, scan_cmp_d;   // column 3 sampled, classify next cycle

  // Scan classification
  logic        scan_done_q, scan_done_d;
  logic        cls_none_q, cls_none_d;
  logic        cls_multi_q, cls_multi_d;
  logic [3:0]  cls_code_q, cls_code_d;

  // Debounce FSM
  logic [1:0]  state_q, state_d;
  logic [3:0]  cand_q, cand_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  rcnt_q, rcnt_d;

  // Display write interface
  logic [3:0]  data_q, data_d;
  logic [1:0]  pos_q, pos_d;
  logic        load_q, load_d;
  logic        multi_q, multi_d;

  // Combinational helpers
  logic [1:0]  col_idx;
  logic        col_tick;
  logic [4:0]  key_count;
  logic [3:0]  key_code;
  logic        cls_single;

  // Column index of the currently driven one-hot column.
  always_comb begin
    col_idx = 2'd0;
    case (col_q)
      4'b0010: col_idx = 2'd1;
      4'b0100: col_idx = 2'd2;
      4'b1000: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  assign col_tick = (div_cnt_q == SCAN_DIV - 16'd1);

  // Count the keys in the completed scan and pick out the code of one of them.
  // The code is only meaningful when exactly one key is present.
  always_comb begin
    key_count = 5'd0;
    key_code  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (scan_buf_q[4'(i)]) begin
        key_count = key_count + 5'd1;
        key_code  = 4'(i);
      end
    end
  end

  assign cls_single = !cls_none_q && !cls_multi_q;

  always_comb begin
    // The synchronizer runs regardless of ena.
    sync1_d     = row_in;
    sync2_d     = sync1_q;

    div_cnt_d   = div_cnt_q;
    col_d       = col_q;
    scan_buf_d  = scan_buf_q;
    scan_cmp_d  = scan_cmp_q;
    cls_none_d  = cls_none_q;
    cls_multi_d = cls_multi_q;
    cls_code_d  = cls_code_q;
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    rcnt_d      = rcnt_q;
    data_d      = data_q;
    pos_d       = pos_q;
    multi_d     = multi_q;
    // Strobes default low so that they last one cycle and are dropped
    // (not deferred) whenever ena is low.
    scan_done_d = 1'b0;
    load_d      = 1'b0;

    if (ena) begin
      // Classify the scan one cycle after its last column was stored.
      if (scan_cmp_q) begin
        scan_cmp_d  = 1'b0;
        scan_done_d = 1'b1;
        cls_none_d  = (key_count == 5'd0);
        cls_multi_d = (key_count >= 5'd2);
        cls_code_d  = key_code;
      end

      if (col_tick) begin
        div_cnt_d = 16'd0;
        for (int r = 0; r < 4; r++) begin
          scan_buf_d[{2'(r), col_idx}] = sync2_q[2'(r)];
        end
        col_d = {col_q[2:0], col_q[3]};
        if (col_q[3]) begin
          scan_cmp_d = 1'b1;
        end
      end else begin
        div_cnt_d = div_cnt_q + 16'd1;
      end

      // The slot advances after the write has been presented for one cycle.
      if (load_q) begin
        pos_d = pos_q + 2'd1;
      end

      if (scan_done_q) begin
        multi_d = cls_multi_q;
        case (state_q)
          ST_IDLE: begin
            if (cls_single) begin
              cand_d = cls_code_q;
              if (DEBOUNCE_SCANS <= 8'd1) begin
                data_d  = cls_code_q;
                load_d  = 1'b1;
                rcnt_d  = 8'd0;
                state_d = ST_HELD;
              end else begin
                cnt_d   = 8'd1;
                state_d = ST_DEBOUNCE;
              end
            end
          end
          ST_DEBOUNCE: begin
            if (cls_single) begin
              if (cls_code_q == cand_q) begin
                if (cnt_q + 8'd1 >= DEBOUNCE_SCANS) begin
                  data_d  = cand_q;
                  load_d  = 1'b1;
                  rcnt_d  = 8'd0;
                  state_d = ST_HELD;
                end else begin
                  cnt_d = cnt_q + 8'd1;
                end
              end else begin
                // A different single key restarts qualification on that key.
                cand_d = cls_code_q;
                cnt_d  = 8'd1;
              end
            end else begin
              state_d = ST_IDLE;
            end
          end
          ST_HELD: begin
            // Only a run of empty scans releases; any key activity (including
            // a new key) restarts the release count, so there is no repeat.
            if (cls_none_q) begin
              if (rcnt_q + 8'd1 >= DEBOUNCE_SCANS) begin
                rcnt_d  = 8'd0;
                state_d = ST_IDLE;
              end else begin
                rcnt_d = rcnt_q + 8'd1;
              end
            end else begin
              rcnt_d = 8'd0;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 4'd0;
      sync2_q     <= 4'd0;
      div_cnt_q   <= 16'd0;
      col_q       <= 4'b0001;
      scan_buf_q  <= 16'd0;
      scan_cmp_q  <= 1'b0;
      scan_done_q <= 1'b0;
      cls_none_q  <= 1'b1;
      cls_multi_q <= 1'b0;
      cls_code_q  <= 4'd0;
      state_q     <= ST_IDLE;
      cand_q      <= 4'd0;
      cnt_q       <= 8'd0;
      rcnt_q      <= 8'd0;
      data_q      <= 4'd0;
      pos_q       <= 2'd0;
      load_q      <= 1'b0;
      multi_q     <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      div_cnt_q   <= div_cnt_d;
      col_q       <= col_d;
      scan_buf_q  <= scan_buf_d;
      scan_cmp_q  <= scan_cmp_d;
      scan_done_q <= scan_done_d;
      cls_none_q  <= cls_none_d;
      cls_multi_q <= cls_multi_d;
      cls_code_q  <= cls_code_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      rcnt_q      <= rcnt_d;
      data_q      <= data_d;
      pos_q       <= pos_d;
      load_q      <= load_d;
      multi_q     <= multi_d;
    end
  end

  assign col_out       = col_q;
  assign data_out      = data_q;
  assign char_position = pos_q;
  assign load          = load_q & ena;
  assign key_held      = (state_q == ST_HELD);
  assign multi_key     = multi_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_matrix_scanner
//
// Directed and random key patterns, each held for whole scans, against a
// scan-level reference model of the debounce rules.
// -----------------------------------------------------------------------------
module tb_keypad_matrix_scanner;

  localparam int DEB = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        ena;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  data_out;
  logic [1:0]  char_position;
  logic        load;
  logic        key_held;
  logic        multi_key;

  logic [15:0] keys;   // bit row*4+col = key physically pressed

  int checks   = 0;
  int failures = 0;

  // Reference model state (scan level)
  bit armed;
  int run_code, run_len, none_run;
  bit pend_valid;
  int pend_kind, pend_code;   // kind: 0 none, 1 single, 2 multi
  bit held_m, multi_m, load_m, pos_bump;
  int data_m, pos_m;
  int cyc, first_load;

  always #5 clk = ~clk;

  keypad_matrix_scanner #(
    .SCAN_DIV       (16'd4),
    .DEBOUNCE_SCANS (8'd2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ena           (ena),
    .row_in        (row_in),
    .col_out       (col_out),
    .data_out      (data_out),
    .char_position (char_position),
    .load          (load),
    .key_held      (key_held),
    .multi_key     (multi_key)
  );

  // Physical matrix: a row reads high when a pressed key sits on a driven column.
  always_comb begin
    row_in = 4'd0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[{2'(r), 2'(c)}] && col_out[2'(c)]) row_in[2'(r)] = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic classify(input logic [15:0] k, output int kind, output int code);
    int n;
    n = 0;
    code = 0;
    for (int i = 0; i < 16; i++) begin
      if (k[4'(i)]) begin
        n++;
        code = i;
      end
    end
    kind = (n == 0) ? 0 : ((n == 1) ? 1 : 2);
  endtask

  // Apply the debounce rules to the previous scan's result.
  task automatic apply_pending();
    load_m = 1'b0;
    if (pend_valid) begin
      pend_valid = 1'b0;
      multi_m = (pend_kind == 2);
      if (armed) begin
        if (pend_kind == 1) begin
          run_len  = (run_len > 0 && run_code == pend_code) ? run_len + 1 : 1;
          run_code = pend_code;
          if (run_len >= DEB) begin
            load_m   = 1'b1;
            data_m   = pend_code;
            pos_bump = 1'b1;
            armed    = 1'b0;
            none_run = 0;
            run_len  = 0;
          end
        end else begin
          run_len = 0;
        end
      end else begin
        if (pend_kind == 0) begin
          none_run++;
          if (none_run >= DEB) begin
            armed    = 1'b1;
            none_run = 0;
            run_len  = 0;
          end
        end else begin
          none_run = 0;
        end
      end
      held_m = !armed;
    end
  endtask

  task automatic check_outputs(input int colidx);
    check("col_out", 32'(col_out), 32'(1) << colidx);
    check("load", 32'(load), 32'(load_m));
    check("data_out", 32'(data_out), 32'(data_m));
    check("char_position", 32'(char_position), 32'(pos_m));
    check("key_held", 32'(key_held), 32'(held_m));
    check("multi_key", 32'(multi_key), 32'(multi_m));
  endtask

  task automatic record_scan(input logic [15:0] k);
    int kind, code;
    classify(k, kind, code);
    pend_valid = 1'b1;
    pend_kind  = kind;
    pend_code  = code;
  endtask

  // One full scan (16 clocks) with a fixed key set; starts right after the
  // column-3 sample edge of the previous scan (or right after reset release).
  task automatic run_scan(input logic [15:0] k);
    keys = k;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (i == 1) apply_pending();
      else load_m = 1'b0;
      if (i == 2 && pos_bump) begin
        pos_m    = (pos_m + 1) % 4;
        pos_bump = 1'b0;
      end
      if (load === 1'b1 && first_load < 0) first_load = cyc;
      check_outputs(((i + 1) >> 2) & 3);
    end
    record_scan(k);
  endtask

  // A scan during which ena is low for 16 clocks, starting on the clock that
  // would have consumed the previous scan's result: that result is lost.
  task automatic run_scan_frozen(input logic [15:0] k);
    int a;
    keys = k;
    for (int e = 0; e < 32; e++) begin
      @(posedge clk);
      #1;
      a = (e <= 16) ? 0 : e - 16;
      load_m = 1'b0;
      if (e == 1) pend_valid = 1'b0;
      check_outputs(((a + 1) >> 2) & 3);
      if (e == 0) ena = 1'b0;
      if (e == 16) ena = 1'b1;
    end
    record_scan(k);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_col_out", 32'(col_out), 32'd1);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_char_position", 32'(char_position), 32'd0);
    check("rst_load", 32'(load), 32'd0);
    check("rst_key_held", 32'(key_held), 32'd0);
    check("rst_multi_key", 32'(multi_key), 32'd0);
    armed = 1'b1; run_code = 0; run_len = 0; none_run = 0;
    pend_valid = 1'b0; pend_kind = 0; pend_code = 0;
    held_m = 1'b0; multi_m = 1'b0; load_m = 1'b0; pos_bump = 1'b0;
    data_m = 0; pos_m = 0;
    cyc = -1;
    keys = 16'd0;
    reset = 1'b0;
  endtask

  initial begin
    int seq [5];
    logic [15:0] rk;
    int hold;
    seq = '{0, 5, 10, 15, 3};
    reset = 1'b1;
    ena   = 1'b1;
    keys  = 16'd0;
    first_load = -1;

    // Idle matrix: columns rotate, nothing is written.
    do_reset();
    repeat (3) run_scan(16'd0);

    // r1c2 held from release of reset: one write of code 6 in slot 0.
    do_reset();
    first_load = -1;
    repeat (4) run_scan(16'h0040);
    check("t2_load_cycle", 32'(first_load), 32'd33);
    check("t2_data_out", 32'(data_out), 32'd6);
    check("t2_char_position", 32'(char_position), 32'd1);
    check("t2_key_held", 32'(key_held), 32'd1);
    repeat (3) run_scan(16'd0);

    // Separate presses fill slots 0..3 and wrap to 0.
    do_reset();
    for (int n = 0; n < 5; n++) begin
      repeat (3) run_scan(16'd1 << seq[n]);
      repeat (3) run_scan(16'd0);
    end
    check("t3_data_out", 32'(data_out), 32'd3);
    check("t3_char_position", 32'(char_position), 32'd1);

    // Two keys at once: flagged, not written; the survivor is then written.
    repeat (3) run_scan(16'h8001);
    check("t4_multi_key", 32'(multi_key), 32'd1);
    repeat (3) run_scan(16'h0001);
    repeat (3) run_scan(16'd0);
    check("t4_data_out", 32'(data_out), 32'd0);

    // Bouncing r2c1, then a genuine long hold with no repeat.
    run_scan(16'h0200);
    run_scan(16'h0000);
    run_scan(16'h0200);
    run_scan(16'h0000);
    run_scan(16'h0000);
    repeat (12) run_scan(16'h0200);
    check("t5_data_out", 32'(data_out), 32'd9);
    repeat (3) run_scan(16'd0);

    // Reset while the press is still being debounced.
    repeat (2) run_scan(16'h0040);
    do_reset();
    repeat (4) run_scan(16'd0);

    // ena low across the emitting scan.
    repeat (2) run_scan(16'h0020);
    run_scan_frozen(16'h0020);
    repeat (2) run_scan(16'h0020);
    repeat (3) run_scan(16'd0);

    // Random key activity, each pattern held for a few scans.
    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: rk = 16'd0;
        4, 5, 6, 7, 8: rk = 16'd1 << $urandom_range(0, 15);
        default: rk = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
      endcase
      hold = $urandom_range(1, 4);
      for (int h = 0; h < hold; h++) run_scan(rk);
    end
    repeat (3) run_scan(16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
